mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of the execute datapath. Accepts an LDR/STR/LDRB/STRB from
//  execute (address = datapath_out, store data = str_data) and runs it on a variable-latency
//  data-memory req/ack bus. Returns load data to the regfile LDR write port (w_data_ldr,
//  w_addr_ldr, w_en_ldr), which also feeds the datapath forwarding muxes. Stalls execute while busy.
// PARAMETERS
//  ADDR_W       11  data-memory address width; the low ADDR_W bits of ex_addr are used
//  TIMEOUT_CYC  64  max cycles mem_req may wait for mem_ack; 0 disables the timeout
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  ex_valid     in   1       execute presents an op this cycle
//  ex_ready     out  1       stage can accept; transfer = ex_valid & ex_ready
//  ex_is_ldr    in   1       op is a load
//  ex_is_str    in   1       op is a store (ex_is_ldr & ex_is_str together is illegal; treated as load)
//  ex_byte      in   1       byte access (LDRB/STRB); 0 = word
//  ex_addr      in   32      effective address (execute datapath_out)
//  ex_str_data  in   32      store data (execute str_data)
//  ex_rd        in   4       load destination register
//  mem_req      out  1       bus request, held until acked
//  mem_we       out  1       1 = write
//  mem_addr     out  ADDR_W  byte address; low 2 bits forced to 0 for word access
//  mem_be       out  4       byte enables
//  mem_wdata    out  32      write data
//  mem_rdata    in   32      read data, valid in the mem_ack cycle
//  mem_ack      in   1       completes the request; may be high in the first mem_req cycle
//  w_data_ldr   out  32      load result to regfile / forwarding
//  w_addr_ldr   out  4       load destination
//  w_en_ldr     out  1       one-cycle regfile write strobe
//  mem_err      out  1       sticky timeout flag, cleared only by rst
// BEHAVIOUR
//  - Reset: state IDLE; ex_ready=1; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0;
//    w_en_ldr=0, w_data_ldr=0, w_addr_ldr=0; mem_err=0; timeout counter 0. Reset mid-transfer
//    drops mem_req immediately, and no writeback occurs.
//  - FSM: IDLE -> REQ on transfer with ex_is_ldr|ex_is_str. Transfer with neither flag is consumed
//    and has no effect (stays IDLE).
//  - REQ: all mem_* outputs are registered at accept and stay stable until ack. On mem_ack:
//    load -> capture the extracted data and go to WB; store -> go to IDLE.
//  - WB: w_en_ldr=1 for exactly one cycle with w_data_ldr/w_addr_ldr, then IDLE. w_data_ldr and
//    w_addr_ldr hold their last values afterwards.
//  - ex_ready=1 only in IDLE; no new op is accepted in REQ or WB.
//  - Latency, zero-wait memory: accept edge C0; mem_req high in cycle C1; ack in C1;
//    w_en_ldr high in C2; ex_ready high again in C3 (load) or C2 (store).
//  - Word access: mem_be=4'hF; mem_addr[1:0]=0 (misaligned address silently aligned down);
//    load data unmodified.
//  - Byte access: lane = ex_addr[1:0]; mem_be = 1<<lane; mem_wdata = {4{ex_str_data[7:0]}}.
//    Load result = zero-extended mem_rdata[8*lane+7 -: 8].
//  - Timeout (TIMEOUT_CYC>0): the counter resets on entry to REQ and increments each REQ cycle
//    without ack. When it reaches TIMEOUT_CYC: drop mem_req, set mem_err, go IDLE, no writeback.
//    An ack in the same cycle as the limit wins, and the access completes normally.
//  - ex_rd=15 loads are written like any other register; PC redirect is the regfile's job.
// STRUCTURE
//  - mem_stage_pkg: state enum {IDLE, REQ, WB}; BE_WORD=4'hF; lane-select helper function.
//  - One sub-module, byte_lane_unit (combinational): store replicate/byte-enable generation and
//    load lane extract/zero-extend. FSM, timeout counter and output registers stay in this module.
// TESTING
//  1 Zero-wait LDR addr 0x40, rdata 0xDEADBEEF, rd=3 -> mem_req in C1 only; w_en_ldr in C2,
//    w_data 0xDEADBEEF, w_addr 3.
//  2 STRB addr 0x103, data 0x12345678, 3-cycle ack -> mem_be=4'b1000, mem_wdata=0x78787878,
//    addr/data stable until ack; no w_en_ldr.
//  3 LDRB addr 0x42, rdata 0xAABBCCDD -> w_data_ldr=0x000000BB; word LDR addr 0x43 -> mem_addr=0x40.
//  4 Op presented while busy (REQ and WB) -> ex_ready=0, op held and accepted only after return to IDLE.
//  5 TIMEOUT_CYC=4, ack never arrives -> mem_req drops after 4 cycles, mem_err=1 sticky,
//    no w_en_ldr; next op proceeds normally.
//  6 rst asserted mid-REQ -> all outputs return to reset values asynchronously; a late ack is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory access stage.
package mem_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned REG_W  = 4;

   localparam logic [BE_W-1:0] BE_WORD = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WB   = 2'd2
   } state_e;

   // Byte lane addressed by the two low address bits.
   function automatic logic [1:0] lane_sel(input logic [DATA_W-1:0] addr);
      return addr[1:0];
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering: store replicate / byte enables and load lane extract.
module byte_lane_unit
   import mem_stage_pkg::*;
(
   input  logic              st_byte,
   input  logic [1:0]        st_lane,
   input  logic [DATA_W-1:0] st_data,
   input  logic              ld_byte,
   input  logic [1:0]        ld_lane,
   input  logic [DATA_W-1:0] ld_rdata,
   output logic [BE_W-1:0]   st_be_c,
   output logic [DATA_W-1:0] st_wdata_c,
   output logic [DATA_W-1:0] ld_data_c
);

   // Store side: one-hot enable and replicated byte for byte stores.
   always_comb begin
      st_be_c    = BE_WORD;
      st_wdata_c = st_data;
      if (st_byte) begin
         st_be_c    = BE_W'(4'b0001 << st_lane);
         st_wdata_c = {4{st_data[7:0]}};
      end
   end

   // Load side: selected lane zero-extended for byte loads.
   always_comb begin
      ld_data_c = ld_rdata;
      if (ld_byte) begin
         ld_data_c = {24'h000000, ld_rdata[{ld_lane, 3'b000} +: 8]};
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: runs one load/store at a time on a req/ack data bus and
// returns load results to the regfile LDR write port.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_is_ldr,
   input  logic              ex_is_str,
   input  logic              ex_byte,
   input  logic [DATA_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_str_data,
   input  logic [REG_W-1:0]  ex_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BE_W-1:0]   mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] w_data_ldr,
   output logic [REG_W-1:0]  w_addr_ldr,
   output logic              w_en_ldr,
   output logic              mem_err
);

   localparam bit              TO_EN    = (TIMEOUT_CYC != 0);
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC + 1) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

   state_e             state_q, state_d;
   logic               is_ld_q, is_ld_d;
   logic               byte_q, byte_d;
   logic [1:0]         lane_q, lane_d;
   logic [REG_W-1:0]   rd_q, rd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               ex_ready_d, mem_req_d, mem_we_d, w_en_d, err_d;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic [BE_W-1:0]    mem_be_d;
   logic [DATA_W-1:0]  mem_wdata_d, w_data_d;
   logic [REG_W-1:0]   w_addr_d;

   logic               accept_c, mem_op_c, timeout_c;
   logic [BE_W-1:0]    st_be_c;
   logic [DATA_W-1:0]  st_wdata_c, ld_data_c;
   logic               unused_addr_hi;

   assign accept_c  = ex_valid & ex_ready;
   assign mem_op_c  = ex_is_ldr | ex_is_str;
   assign timeout_c = TO_EN && (state_q == REQ) && !mem_ack && (cnt_q == LAST_CNT);
   assign unused_addr_hi = ^ex_addr[DATA_W-1:ADDR_W];

   byte_lane_unit u_lanes (
      .st_byte    (ex_byte),
      .st_lane    (lane_sel(ex_addr)),
      .st_data    (ex_str_data),
      .ld_byte    (byte_q),
      .ld_lane    (lane_q),
      .ld_rdata   (mem_rdata),
      .st_be_c    (st_be_c),
      .st_wdata_c (st_wdata_c),
      .ld_data_c  (ld_data_c)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; an ack in the limit cycle takes priority over timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c && mem_op_c) state_d = REQ;
         REQ: begin
            if (mem_ack)        state_d = is_ld_q ? WB : IDLE;
            else if (timeout_c) state_d = IDLE;
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs and transaction context.
   always_comb begin
      ex_ready_d  = (state_d == IDLE);
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_be_d    = mem_be;
      mem_wdata_d = mem_wdata;
      w_data_d    = w_data_ldr;
      w_addr_d    = w_addr_ldr;
      w_en_d      = 1'b0;
      err_d       = mem_err;
      is_ld_d     = is_ld_q;
      byte_d      = byte_q;
      lane_d      = lane_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_c && mem_op_c) begin
               mem_req_d   = 1'b1;
               mem_we_d    = ex_is_str & ~ex_is_ldr;
               mem_addr_d  = ex_byte ? ex_addr[ADDR_W-1:0]
                                     : {ex_addr[ADDR_W-1:2], 2'b00};
               mem_be_d    = st_be_c;
               mem_wdata_d = st_wdata_c;
               is_ld_d     = ex_is_ldr;
               byte_d      = ex_byte;
               lane_d      = lane_sel(ex_addr);
               rd_d        = ex_rd;
               cnt_d       = '0;
            end
         end
         REQ: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (is_ld_q) begin
                  w_data_d = ld_data_c;
                  w_addr_d = rd_q;
                  w_en_d   = 1'b1;
               end
            end else if (timeout_c) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               err_d     = 1'b1;
            end else if (TO_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Output and context registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_ready   <= 1'b1;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         w_data_ldr <= '0;
         w_addr_ldr <= '0;
         w_en_ldr   <= 1'b0;
         mem_err    <= 1'b0;
         is_ld_q    <= 1'b0;
         byte_q     <= 1'b0;
         lane_q     <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         ex_ready   <= ex_ready_d;
         mem_req    <= mem_req_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_be     <= mem_be_d;
         mem_wdata  <= mem_wdata_d;
         w_data_ldr <= w_data_d;
         w_addr_ldr <= w_addr_d;
         w_en_ldr   <= w_en_d;
         mem_err    <= err_d;
         is_ld_q    <= is_ld_d;
         byte_q     <= byte_d;
         lane_q     <= lane_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a transaction-level model.
module tb_mem_access_stage;

   localparam int unsigned AW = 11;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_is_ldr, ex_is_str, ex_byte;
   logic [31:0] ex_addr, ex_str_data;
   logic [3:0]  ex_rd;
   logic        mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;
   logic [31:0] w_data_ldr;
   logic [3:0]  w_addr_ldr;
   logic        w_en_ldr, mem_err;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state: sticky error and last regfile write values.
   bit          exp_err = 1'b0;
   logic [31:0] hold_wdata = '0;
   logic [3:0]  hold_waddr = '0;

   // Op held on the input while the stage is busy.
   bit          busy_valid = 1'b0;
   bit          p_ldr, p_str, p_byte;
   logic [31:0] p_addr, p_data;
   logic [3:0]  p_rd;

   mem_access_stage #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_is_ldr   (ex_is_ldr),
      .ex_is_str   (ex_is_str),
      .ex_byte     (ex_byte),
      .ex_addr     (ex_addr),
      .ex_str_data (ex_str_data),
      .ex_rd       (ex_rd),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .w_data_ldr  (w_data_ldr),
      .w_addr_ldr  (w_addr_ldr),
      .w_en_ldr    (w_en_ldr),
      .mem_err     (mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input bit ldr, input bit str, input bit byt,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] rd);
      ex_valid    = 1'b1;
      ex_is_ldr   = ldr;
      ex_is_str   = str;
      ex_byte     = byt;
      ex_addr     = addr;
      ex_str_data = data;
      ex_rd       = rd;
   endtask

   task automatic after_accept;
      if (busy_valid) drive_op(p_ldr, p_str, p_byte, p_addr, p_data, p_rd);
      else            ex_valid = 1'b0;
   endtask

   // One complete operation; delay = REQ cycles before ack (>= TO means never acked).
   task automatic run_op(input bit ldr, input bit str, input bit byt,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] rd, input int delay,
                         input logic [31:0] rdata);
      logic [1:0]    lane;
      logic [3:0]    exp_be;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_wd, exp_ld;
      bit            acked;
      lane     = addr[1:0];
      exp_be   = byt ? 4'(4'b0001 << lane) : 4'hF;
      exp_addr = byt ? addr[AW-1:0] : (addr[AW-1:0] & ~AW'(3));
      exp_wd   = byt ? {4{data[7:0]}} : data;
      exp_ld   = byt ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;

      drive_op(ldr, str, byt, addr, data, rd);
      chk("ready_before_accept", 32'(ex_ready), 32'd1);
      tick();
      after_accept();

      if (!(ldr || str)) begin
         chk("noop_req", 32'(mem_req), 32'd0);
         chk("noop_ready", 32'(ex_ready), 32'd1);
         chk("noop_wen", 32'(w_en_ldr), 32'd0);
         return;
      end

      acked = 1'b0;
      for (int k = 0; k < TO; k++) begin
         mem_ack   = (k == delay);
         mem_rdata = (k == delay) ? rdata : $urandom;
         chk("req_high", 32'(mem_req), 32'd1);
         chk("req_we", 32'(mem_we), 32'(str && !ldr));
         chk("req_addr", 32'(mem_addr), 32'(exp_addr));
         chk("req_be", 32'(mem_be), 32'(exp_be));
         chk("req_wdata", mem_wdata, exp_wd);
         chk("busy_ready", 32'(ex_ready), 32'd0);
         chk("busy_wen", 32'(w_en_ldr), 32'd0);
         tick();
         mem_ack = 1'b0;
         if (k == delay) begin
            acked = 1'b1;
            break;
         end
      end

      if (!acked) begin
         exp_err = 1'b1;
         chk("to_req", 32'(mem_req), 32'd0);
         chk("to_err", 32'(mem_err), 32'd1);
         chk("to_wen", 32'(w_en_ldr), 32'd0);
         chk("to_ready", 32'(ex_ready), 32'd1);
         chk("to_wdata_hold", w_data_ldr, hold_wdata);
      end else if (ldr) begin
         chk("wb_wen", 32'(w_en_ldr), 32'd1);
         chk("wb_data", w_data_ldr, exp_ld);
         chk("wb_addr", 32'(w_addr_ldr), 32'(rd));
         chk("wb_req", 32'(mem_req), 32'd0);
         chk("wb_ready", 32'(ex_ready), 32'd0);
         hold_wdata = exp_ld;
         hold_waddr = rd;
         tick();
         chk("post_wb_wen", 32'(w_en_ldr), 32'd0);
         chk("post_wb_ready", 32'(ex_ready), 32'd1);
         chk("post_wb_data_hold", w_data_ldr, hold_wdata);
         chk("post_wb_addr_hold", 32'(w_addr_ldr), 32'(hold_waddr));
      end else begin
         chk("st_done_req", 32'(mem_req), 32'd0);
         chk("st_done_wen", 32'(w_en_ldr), 32'd0);
         chk("st_done_ready", 32'(ex_ready), 32'd1);
         chk("st_wdata_hold", w_data_ldr, hold_wdata);
      end
      chk("err_state", 32'(mem_err), 32'(exp_err));
   endtask

   initial begin
      rst = 1'b1;
      ex_valid = 1'b0; ex_is_ldr = 1'b0; ex_is_str = 1'b0; ex_byte = 1'b0;
      ex_addr = '0; ex_str_data = '0; ex_rd = '0;
      mem_ack = 1'b0; mem_rdata = '0;

      // Reset values.
      tick(); tick();
      chk("rst_ready", 32'(ex_ready), 32'd1);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_wen", 32'(w_en_ldr), 32'd0);
      chk("rst_wdata_ldr", w_data_ldr, 32'd0);
      chk("rst_waddr_ldr", 32'(w_addr_ldr), 32'd0);
      chk("rst_err", 32'(mem_err), 32'd0);
      rst = 1'b0;
      tick();

      // Zero-wait word load.
      run_op(1, 0, 0, 32'h40, 32'h0, 4'd3, 0, 32'hDEADBEEF);
      // Byte store, ack in the third REQ cycle.
      run_op(0, 1, 1, 32'h103, 32'h12345678, 4'd0, 2, 32'h0);
      // Byte load lane 2; misaligned word load.
      run_op(1, 0, 1, 32'h42, 32'h0, 4'd5, 0, 32'hAABBCCDD);
      run_op(1, 0, 0, 32'h43, 32'h0, 4'd6, 1, 32'h01020304);
      // Both flags set behaves as a load; neither flag is a no-op.
      run_op(1, 1, 0, 32'h80, 32'hFFFFFFFF, 4'd15, 0, 32'hCAFEF00D);
      run_op(0, 0, 0, 32'h84, 32'h0, 4'd1, 0, 32'h0);

      // Op held during REQ and WB is accepted only after return to IDLE.
      p_ldr = 0; p_str = 1; p_byte = 0; p_addr = 32'h200; p_data = 32'h55AA55AA; p_rd = 4'd0;
      busy_valid = 1'b1;
      run_op(1, 0, 0, 32'h100, 32'h0, 4'd7, 1, 32'h13572468);
      busy_valid = 1'b0;
      run_op(p_ldr, p_str, p_byte, p_addr, p_data, p_rd, 0, 32'h0);

      // Ack on the limit cycle wins; then a real timeout; then normal traffic.
      run_op(1, 0, 1, 32'h11, 32'h0, 4'd2, TO - 1, 32'h00EE0000 | 32'h0000AB00);
      run_op(1, 0, 0, 32'h300, 32'h0, 4'd9, TO, 32'h0);
      run_op(0, 1, 0, 32'h304, 32'h87654321, 4'd0, 0, 32'h0);

      // Randomized traffic, including occasional timeouts.
      for (int i = 0; i < 60; i++) begin
         int unsigned kind;
         int          dly;
         kind = $urandom_range(0, 9);
         dly  = (($urandom_range(0, 9)) == 0) ? TO : int'($urandom_range(0, TO - 1));
         run_op(kind < 5 || kind == 9, (kind >= 5 && kind < 8) || kind == 9,
                1'($urandom), $urandom, $urandom, 4'($urandom), dly, $urandom);
      end

      // Asynchronous reset mid-REQ; a late ack must be ignored.
      drive_op(1, 0, 0, 32'h500, 32'h0, 4'd4);
      tick();
      ex_valid = 1'b0;
      chk("pre_rst_req", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_req", 32'(mem_req), 32'd0);
      chk("arst_ready", 32'(ex_ready), 32'd1);
      chk("arst_be", 32'(mem_be), 32'd0);
      chk("arst_addr", 32'(mem_addr), 32'd0);
      chk("arst_err", 32'(mem_err), 32'd0);
      chk("arst_wdata_ldr", w_data_ldr, 32'd0);
      exp_err = 1'b0; hold_wdata = '0; hold_waddr = '0;
      tick();
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_ack = 1'b0;
      chk("late_ack_wen", 32'(w_en_ldr), 32'd0);
      chk("late_ack_req", 32'(mem_req), 32'd0);
      chk("late_ack_ready", 32'(ex_ready), 32'd1);
      tick();
      chk("late_ack_wen2", 32'(w_en_ldr), 32'd0);
      chk("late_ack_wdata", w_data_ldr, 32'd0);
      run_op(1, 0, 1, 32'h7, 32'h0, 4'd8, 0, 32'h9A000000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
